// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg                                                             |
// | Shared opcodes, NOP encoding, fetch FSM states and default reset PC. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mips_pkg;

    localparam logic [5:0]  c_op_rtype = 6'd0;
    localparam logic [5:0]  c_op_beq   = 6'd4;
    localparam logic [5:0]  c_op_addi  = 6'd8;
    localparam logic [5:0]  c_op_lw    = 6'd35;
    localparam logic [5:0]  c_op_sw    = 6'd43;

    localparam logic [31:0] c_nop              = 32'h0000_0000;
    localparam logic [31:0] c_default_reset_pc = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_skid                                                           |
// | One-entry buffer for a word accepted from memory while decode stalls.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_skid
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;

    // clear wins so a redirect in the same cycle never leaves a stale entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= c_nop;
            r_pc4   <= 32'h0;
        end else if (clear) begin
            r_valid <= 1'b0;
            r_instr <= c_nop;
            r_pc4   <= 32'h0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_instr <= load_instr;
            r_pc4   <= load_pc4;
        end
    end

    assign valid = r_valid;
    assign instr = r_instr;
    assign pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch                                                          |
// | IF stage: PC, memory request, IF/ID register, stall skid, redirect.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_default_reset_pc
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  opcode
);

    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt, w_pc_inc;
    logic         r_ifid_valid, w_ifid_valid_nxt;
    logic [31:0]  r_ifid_instr, w_ifid_instr_nxt;
    logic [31:0]  r_ifid_pc4, w_ifid_pc4_nxt;
    logic         w_skid_load, w_skid_clear, w_skid_valid;
    logic [31:0]  w_skid_instr, w_skid_pc4;

    assign w_pc_inc = r_pc + 32'd4;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_valid_nxt = r_ifid_valid;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc4_nxt   = r_ifid_pc4;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;

        if (branch_taken) begin
            w_state_nxt      = FETCH;
            w_pc_nxt         = branch_target & c_word_mask;
            w_ifid_valid_nxt = 1'b0;
            w_ifid_instr_nxt = c_nop;
            w_skid_clear     = 1'b1;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        w_pc_nxt = w_pc_inc;
                        if (stall) begin
                            // decode is busy: park the returned word, stop fetching
                            w_skid_load = 1'b1;
                            w_state_nxt = HOLD;
                        end else begin
                            w_ifid_valid_nxt = 1'b1;
                            w_ifid_instr_nxt = imem_rdata;
                            w_ifid_pc4_nxt   = w_pc_inc;
                        end
                    end else if (!stall) begin
                        w_ifid_valid_nxt = 1'b0;
                        w_ifid_instr_nxt = c_nop;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        w_ifid_valid_nxt = w_skid_valid;
                        w_ifid_instr_nxt = w_skid_instr;
                        w_ifid_pc4_nxt   = w_skid_pc4;
                        w_skid_clear     = 1'b1;
                        w_state_nxt      = FETCH;
                    end
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC & c_word_mask;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= c_nop;
            r_ifid_pc4   <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
        end
    end

    fetch_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_skid_load),
        .clear      (w_skid_clear),
        .load_instr (imem_rdata),
        .load_pc4   (w_pc_inc),
        .valid      (w_skid_valid),
        .instr      (w_skid_instr),
        .pc4        (w_skid_pc4)
    );

    // reset gates the request combinationally so an in-flight fetch is abandoned at once
    assign imem_req   = rst_n && (r_state == FETCH);
    assign imem_addr  = r_pc;
    assign ifid_valid = r_ifid_valid;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc4   = r_ifid_pc4;
    assign opcode     = r_ifid_instr[31:26];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_instr_fetch                                                       |
// | Directed scenarios plus randomized run against an in-order model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instr_fetch;

    localparam logic [31:0] c_scr = 32'h5A5A_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-RESET_PC instance
    logic        rst_n, imem_ack, stall, branch_taken, imem_req, ifid_valid, scramble;
    logic [31:0] branch_target, imem_addr, imem_rdata, ifid_instr, ifid_pc4;
    logic [5:0]  opcode;
    assign imem_rdata = scramble ? (imem_addr ^ c_scr) : imem_addr;

    // wrap-around instance
    logic        rst_n1, ack1, stall1, br1, req1, valid1;
    logic [31:0] tgt1, addr1, rdata1, instr1, pc4_1;
    logic [5:0]  op1;
    assign rdata1 = addr1;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .opcode(opcode)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n1), .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack1), .imem_rdata(rdata1), .stall(stall1),
        .branch_taken(br1), .branch_target(tgt1),
        .ifid_valid(valid1), .ifid_instr(instr1), .ifid_pc4(pc4_1),
        .opcode(op1)
    );

    // Reference: instructions accepted from memory but not yet taken by decode, oldest first.
    entry_t      q[$];
    logic [31:0] exp_pc;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return scramble ? (a ^ c_scr) : a;
    endfunction

    task automatic step(input logic a, input logic s, input logic b, input logic [31:0] t);
        int     n;
        entry_t e;
        imem_ack = a; stall = s; branch_taken = b; branch_target = t;
        n = q.size();
        if (b) begin
            q.delete();
            exp_pc = {t[31:2], 2'b00};
        end else begin
            if (!s && n > 0) void'(q.pop_front());
            if (n < 2 && a) begin
                e.instr = mem_word(exp_pc);
                e.pc4   = exp_pc + 32'd4;
                q.push_back(e);
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset0();
        imem_ack = 0; stall = 0; branch_taken = 0; branch_target = 0;
        rst_n = 0;
        @(posedge clk); #3;
        rst_n = 1; #1;
        q.delete();
        exp_pc = 32'h0;
    endtask

    task automatic test_reset();
        do_reset0();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        #2 rst_n = 0; #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req_async got=%b exp=0", imem_req); end
        vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
        vectors++; if (ifid_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got=%h exp=0", ifid_instr); end
        vectors++; if (ifid_pc4 !== 32'h0) begin miscompares++; $display("FAIL reset_pc4 got=%h exp=0", ifid_pc4); end
        vectors++; if (opcode !== 6'h0) begin miscompares++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
        @(posedge clk); #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req_held got=%b exp=0", imem_req); end
        rst_n = 1; #1;
        q.delete(); exp_pc = 32'h0;
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL reset_req_after got=%b exp=1", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr_after got=%h exp=0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] w;
        do_reset0();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            w = 32'(i * 4);
            vectors++; if (ifid_valid !== 1'b1) begin miscompares++; $display("FAIL zw_valid[%0d] got=%b exp=1", i, ifid_valid); end
            vectors++; if (ifid_instr !== w) begin miscompares++; $display("FAIL zw_instr[%0d] got=%h exp=%h", i, ifid_instr, w); end
            vectors++; if (ifid_pc4 !== w + 32'd4) begin miscompares++; $display("FAIL zw_pc4[%0d] got=%h exp=%h", i, ifid_pc4, w + 32'd4); end
            vectors++; if (opcode !== w[31:26]) begin miscompares++; $display("FAIL zw_opcode[%0d] got=%h exp=%h", i, opcode, w[31:26]); end
        end
        vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL zw_next_addr got=%h exp=10", imem_addr); end
    endtask

    task automatic test_ack_delay();
        logic [31:0] a;
        for (int f = 0; f < 3; f++) begin
            a = 32'h10 + 32'(f * 4);
            for (int k = 0; k < 3; k++) begin
                step(k == 2, 0, 0, 0);
                vectors++; if (ifid_valid !== (k == 2)) begin miscompares++; $display("FAIL dly_valid[%0d.%0d] got=%b exp=%b", f, k, ifid_valid, k == 2); end
                if (k < 2) begin
                    vectors++; if (imem_addr !== a) begin miscompares++; $display("FAIL dly_addr[%0d.%0d] got=%h exp=%h", f, k, imem_addr, a); end
                    vectors++; if (ifid_instr !== 32'h0) begin miscompares++; $display("FAIL dly_nop[%0d.%0d] got=%h exp=0", f, k, ifid_instr); end
                end else begin
                    vectors++; if (ifid_instr !== a) begin miscompares++; $display("FAIL dly_instr[%0d] got=%h exp=%h", f, ifid_instr, a); end
                end
            end
        end
    endtask

    task automatic test_stall_skid();
        do_reset0();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0);
            vectors++; if (ifid_instr !== 32'hC || ifid_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/0000000c", k, ifid_valid, ifid_instr); end
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_hold_req[%0d] got=%b exp=0", k, imem_req); end
        end
        step(1, 0, 0, 0);
        vectors++; if (ifid_instr !== 32'h10 || ifid_valid !== 1'b1) begin miscompares++; $display("FAIL stall_release got=%b/%h exp=1/00000010", ifid_valid, ifid_instr); end
        vectors++; if (ifid_pc4 !== 32'h14) begin miscompares++; $display("FAIL stall_release_pc4 got=%h exp=14", ifid_pc4); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin miscompares++; $display("FAIL stall_resume_req got=%b/%h exp=1/00000014", imem_req, imem_addr); end
        step(1, 0, 0, 0);
        vectors++; if (ifid_instr !== 32'h14 || ifid_pc4 !== 32'h18) begin miscompares++; $display("FAIL stall_next got=%h/%h exp=14/18", ifid_instr, ifid_pc4); end
    endtask

    task automatic test_branch();
        do_reset0();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        vectors++; if (imem_addr !== 32'h20) begin miscompares++; $display("FAIL br_pre_addr got=%h exp=20", imem_addr); end
        step(1, 0, 1, 32'h43);
        vectors++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin miscompares++; $display("FAIL br_flush got=%b/%h exp=0/0", ifid_valid, ifid_instr); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin miscompares++; $display("FAIL br_addr got=%b/%h exp=1/00000040", imem_req, imem_addr); end
        step(1, 0, 0, 0);
        vectors++; if (ifid_instr !== 32'h40 || ifid_valid !== 1'b1) begin miscompares++; $display("FAIL br_target_instr got=%b/%h exp=1/00000040", ifid_valid, ifid_instr); end
        // redirect while parked in HOLD must drop the skid entry
        step(1, 1, 0, 0);
        step(0, 1, 1, 32'h100);
        vectors++; if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL br_hold got=%b/%b/%h exp=0/1/00000100", ifid_valid, imem_req, imem_addr); end
        step(1, 0, 0, 0);
        vectors++; if (ifid_instr !== 32'h100) begin miscompares++; $display("FAIL br_skid_drop got=%h exp=00000100", ifid_instr); end
    endtask

    task automatic test_wrap();
        imem_ack = 0; stall = 0; branch_taken = 0;
        ack1 = 0; rst_n1 = 0;
        @(posedge clk); #3;
        rst_n1 = 1; #1;
        vectors++; if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wrap_first got=%b/%h exp=1/fffffff8", req1, addr1); end
        ack1 = 1;
        @(posedge clk); #1;
        vectors++; if (addr1 !== 32'hFFFF_FFFC || instr1 !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wrap_second got=%h/%h exp=fffffffc/fffffff8", addr1, instr1); end
        @(posedge clk); #1;
        vectors++; if (addr1 !== 32'h0 || pc4_1 !== 32'h0) begin miscompares++; $display("FAIL wrap_zero got=%h/%h exp=0/0", addr1, pc4_1); end
        ack1 = 0;
        @(posedge clk); #1;
        #2 rst_n1 = 0; #1;
        vectors++; if (req1 !== 1'b0) begin miscompares++; $display("FAIL wrap_rst_req got=%b exp=0", req1); end
        @(posedge clk); #1;
        rst_n1 = 1; #1;
        vectors++; if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFF8 || valid1 !== 1'b0) begin miscompares++; $display("FAIL wrap_restart got=%b/%h/%b exp=1/fffffff8/0", req1, addr1, valid1); end
    endtask

    task automatic test_random();
        logic        a, s, b;
        logic [31:0] t;
        do_reset0();
        scramble = 1;
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 3) != 0);
            s = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(a, s, b, t);
            vectors++; if (imem_req !== (q.size() < 2)) begin miscompares++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, imem_req, q.size() < 2); end
            if (q.size() < 2) begin
                vectors++; if (imem_addr !== exp_pc) begin miscompares++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, imem_addr, exp_pc); end
            end
            vectors++; if (ifid_valid !== (q.size() > 0)) begin miscompares++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, ifid_valid, q.size() > 0); end
            if (q.size() > 0) begin
                vectors++; if (ifid_instr !== q[0].instr || ifid_pc4 !== q[0].pc4) begin miscompares++; $display("FAIL rnd_ifid[%0d] got=%h/%h exp=%h/%h", i, ifid_instr, ifid_pc4, q[0].instr, q[0].pc4); end
                vectors++; if (opcode !== q[0].instr[31:26]) begin miscompares++; $display("FAIL rnd_opcode[%0d] got=%h exp=%h", i, opcode, q[0].instr[31:26]); end
            end else begin
                vectors++; if (ifid_instr !== 32'h0) begin miscompares++; $display("FAIL rnd_nop[%0d] got=%h exp=0", i, ifid_instr); end
            end
        end
        scramble = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; rst_n1 = 0; scramble = 0;
        imem_ack = 0; stall = 0; branch_taken = 0; branch_target = 0;
        ack1 = 0; stall1 = 0; br1 = 0; tgt1 = 0;
        exp_pc = 32'h0;
        #12;
        test_reset();
        test_zero_wait();
        test_ack_delay();
        test_stall_skid();
        test_branch();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
